// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-map pipeline: default geometry and the pixel type.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;

    // Signed two's-complement feature-map pixel at the default width.
    typedef logic signed [DEF_DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/conv33_window_if.sv
// Pixel stream in / 3x3 window stream out of the window generator.
// The slave side is the window generator. The master side is the pixel source and window consumer.
interface conv33_window_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                         pix_valid;
    logic                         pix_sof;
    logic signed [DATA_WIDTH-1:0] pix_in;

    logic                         win_valid;
    logic                         win_last;
    logic                         frame_done;
    logic signed [DATA_WIDTH-1:0] data_0_0, data_0_1, data_0_2;
    logic signed [DATA_WIDTH-1:0] data_1_0, data_1_1, data_1_2;
    logic signed [DATA_WIDTH-1:0] data_2_0, data_2_1, data_2_2;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  win_valid, win_last, frame_done,
        input  data_0_0, data_0_1, data_0_2,
        input  data_1_0, data_1_1, data_1_2,
        input  data_2_0, data_2_1, data_2_2
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output win_valid, win_last, frame_done,
        output data_0_0, data_0_1, data_0_2,
        output data_1_0, data_1_1, data_1_2,
        output data_2_0, data_2_1, data_2_2
    );

endinterface

// File: rtl/conv33_line_buf.sv
// One image row of storage with an asynchronous read and a synchronous write at the same address.
// A read in the same cycle as a write returns the old contents.
module conv33_line_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 28,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the accepted column; the old value stays visible on rdata until the edge.
    // NOTE: the storage has no reset. Every entry is rewritten before it is used, and
    // leaving out the reset keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv33_window.sv
// Streaming 3x3 window generator ("valid" convolution, no padding).
// It tracks the raster position, keeps the two previous rows in line buffers, and
// presents a registered 3x3 neighbourhood with valid/last/frame-done strobes.
module conv33_window
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int COL_W      = $clog2(IMG_W),
    parameter int ROW_W      = $clog2(IMG_H)
) (
    input  logic           clk,
    input  logic           rst,
    conv33_window_if.slave bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]             col;
    logic [ROW_W-1:0]             row;
    logic [COL_W-1:0]             col_eff;
    logic [ROW_W-1:0]             row_eff;
    logic                         at_frame_end;
    logic                         in_grid;
    logic                         lb_we;
    logic [DATA_WIDTH-1:0]        top_rd;
    logic [DATA_WIDTH-1:0]        mid_rd;
    logic signed [DATA_WIDTH-1:0] win [3][3];
    logic                         win_valid_q;
    logic                         win_last_q;
    logic                         frame_done_q;

    // Position of the pixel presented this cycle. Start-of-frame pins it to (0,0).
    // NOTE: combinational logic uses blocking '=' and assigns every output first, so
    // no output is left unassigned on any path and no latch can be inferred.
    always_comb begin
        col_eff      = col;
        row_eff      = row;
        if (bus.pix_sof) begin
            col_eff = '0;
            row_eff = '0;
        end
        at_frame_end = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        in_grid      = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
    end

    assign lb_we = bus.pix_valid && !rst;

    // Row r-2 storage, fed from the row r-1 buffer as it is overwritten.
    conv33_line_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_W),
        .ADDR_W(COL_W)
    ) u_lb_top (
        .clk  (clk),
        .we   (lb_we),
        .addr (col_eff),
        .wdata(mid_rd),
        .rdata(top_rd)
    );

    // Row r-1 storage, fed from the incoming pixel.
    conv33_line_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_W),
        .ADDR_W(COL_W)
    ) u_lb_mid (
        .clk  (clk),
        .we   (lb_we),
        .addr (col_eff),
        .wdata(bus.pix_in),
        .rdata(mid_rd)
    );

    // Raster counters. They advance only on accepted pixels and wrap at the end of a row and of a frame.
    // NOTE: clocked state uses non-blocking '<=' so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_valid) begin
            if (col_eff == COL_LAST) begin
                col <= '0;
                row <= (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col <= col_eff + COL_W'(1);
                row <= row_eff;
            end
        end
    end

    // Shift the window one column left and load the new right column: top, middle, incoming.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (bus.pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= top_rd;
            win[1][2] <= mid_rd;
            win[2][2] <= bus.pix_in;
        end
    end

    // Registered strobes. A window is complete once two rows and two columns lie above and to the left of the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= bus.pix_valid && in_grid;
            win_last_q   <= bus.pix_valid && in_grid && at_frame_end;
            frame_done_q <= bus.pix_valid && at_frame_end;
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_0_0   = win[0][0];
    assign bus.data_0_1   = win[0][1];
    assign bus.data_0_2   = win[0][2];
    assign bus.data_1_0   = win[1][0];
    assign bus.data_1_1   = win[1][1];
    assign bus.data_1_2   = win[1][2];
    assign bus.data_2_0   = win[2][0];
    assign bus.data_2_1   = win[2][1];
    assign bus.data_2_2   = win[2][2];

endmodule

// File: doc/conv33_window.md
Name: conv33_window

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution calculator.
- Accepts one feature-map pixel per cycle in raster order (row-major, col 0 first).
- Keeps the two previous rows in on-chip line buffers and presents a registered 3x3 neighbourhood with a valid strobe that drives the calculator's enable input.
- Valid-only ("no padding") convolution: an (IMG_H-2) x (IMG_W-2) window grid is emitted per frame.

Parameters:
- DATA_WIDTH, 8, pixel width (signed, two's complement; passed through unchanged).
- IMG_W, 28, frame width in pixels; legal range >= 3.
- IMG_H, 28, frame height in pixels; legal range >= 3.
- COL_W, $clog2(IMG_W), column counter width.
- ROW_W, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset; sampled on rising clk.
- pix_valid  in  1  pix_in is accepted this cycle; no backpressure, block always ready.
- pix_sof  in  1  qualified by pix_valid; the accepted pixel is forced to position (0,0).
- pix_in  in  DATA_WIDTH  signed pixel.
- win_valid  out  1  window outputs hold a new complete window; drives conv33_en.
- win_last  out  1  with win_valid, marks the final window of the frame.
- data_0_0 .. data_2_2  out  DATA_WIDTH each (9 ports)  window; row index first, row 0 oldest/top, col 2 newest/right.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (sync): col/row counters = 0; all 9 window regs = 0; win_valid, win_last, frame_done = 0. Line buffer contents are not cleared (never used before being rewritten).
- Counters: on each accepted pixel, col increments; at IMG_W-1 it wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0. No change when pix_valid = 0.
- pix_sof with pix_valid: the pixel is treated as (0,0) and counters become (0,1) next cycle.
  - Any partial frame in progress is abandoned silently: no win_last, no frame_done.
  - pix_sof without pix_valid is ignored.
- Line buffers: lb_top and lb_mid, depth IMG_W, indexed by col. For an accepted pixel at (r,c):
  - Read lb_top[c] = pixel(r-2,c) and lb_mid[c] = pixel(r-1,c).
  - Write lb_top[c] <= old lb_mid[c] and lb_mid[c] <= pix_in.
  - Read-before-write on the same address returns the old value.
- Window shift, on each accepted pixel:
  - Column 0 <= column 1.
  - Column 1 <= column 2.
  - Column 2 <= {lb_top[c], lb_mid[c], pix_in} as rows 0, 1, 2.
- Outputs are registered with latency 1.
  - win_valid <= pix_valid && r >= 2 && c >= 2.
  - win_last <= the same condition && r == IMG_H-1 && c == IMG_W-1.
  - frame_done <= pix_valid && r == IMG_H-1 && c == IMG_W-1.
- When pix_valid = 0: window regs hold and win_valid/win_last/frame_done are 0 next cycle. Gaps of any length are legal and do not corrupt the window.
- Row-boundary windows (c < 2) are internally stale but never flagged valid.
- Back-to-back frames without gap are legal. Row 0 of the new frame reuses buffers; first valid window again at (2,2).

Decomposition:
- Shared package cnn_pkg: DATA_WIDTH default, IMG_W/IMG_H defaults, pixel typedef (signed [DATA_WIDTH-1:0]).
- Sub-module conv33_line_buf: one IMG_W x DATA_WIDTH array with async read and sync write at the same address (read-old semantics).
  - Instantiated twice, or once with 2*DATA_WIDTH width.
- Counter/control and window registers stay in conv33_window.

Test Plan:
1. IMG_W=IMG_H=5, continuous pixels p(r,c) = 5r+c, sof on first → the first win_valid arrives the cycle after pixel 12 is accepted, with data_0_0..0_2 = 0,1,2; 1_0..1_2 = 5,6,7; 2_0..2_2 = 10,11,12.
   - Exactly 9 win_valid pulses.
   - Last window has data_2_2 = 24 and win_last = 1, coincident with frame_done = 1.
2. Same frame with pix_valid deasserted 1-3 random cycles between pixels → identical 9 windows in order; win_valid never high during gaps; window regs stable across gaps.
3. Two frames back-to-back (second frame p+100) → the second frame's first window has data_0_0 = 100 and data_2_2 = 112. No window mixes values from both frames.
4. Assert rst for one cycle after pixel 13 of a frame → next cycle all outputs are 0.
   - The following frame (sof) produces the full 9 correct windows.
5. pix_sof asserted at pixel index 8 of a frame → no win_last or frame_done for the aborted frame; the new frame starting at that pixel yields 9 correct windows.
6. Signed extremes: pixels alternating -128/127 → window values bit-exact, no sign corruption; feed into the calculator and compare against a software model.
